// File: rtl/vita_tx_pkg.sv
// Shared types and constants for the multi-channel timed-transmit controller.
// The FIFO word is {samples, header}; the header layout is captured by hdr_t.
package vita_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RUN        = 3'd1,
    ST_CONT_BURST = 3'd2,
    ST_ERROR      = 3'd3,
    ST_ERROR_DONE = 3'd4,
    ST_ERROR_WAIT = 3'd5
  } state_t;

  localparam logic [15:0] CODE_EOB_ACK            = 16'd1;
  localparam logic [15:0] CODE_UNDERRUN           = 16'd2;
  localparam logic [15:0] CODE_SEQ_ERROR          = 16'd4;
  localparam logic [15:0] CODE_TIME_ERROR         = 16'd8;
  localparam logic [15:0] CODE_UNDERRUN_MIDPKT    = 16'd16;
  localparam logic [15:0] CODE_SEQ_ERROR_MIDBURST = 16'd32;

  localparam int POL_WAIT        = 0;
  localparam int POL_NEXT_PACKET = 1;
  localparam int POL_NEXT_BURST  = 2;
  localparam int POL_LBT_EN      = 3;

  localparam int HDR_W = 85;

  typedef struct packed {
    logic        seqnum_err;
    logic        send_at;
    logic        sob;
    logic        eob;
    logic        eop;
    logic [15:0] seqnum;
    logic [63:0] send_time;
  } hdr_t;

  function automatic int samp_lsb(input int ch, input int width);
    return HDR_W + ch * width;
  endfunction

  function automatic int fifo_w(input int nch, input int width);
    return HDR_W + nch * width;
  endfunction

endpackage

// File: rtl/vita_tx_time_check.sv
// Send-time comparison for the FIFO head word, plus the two-cycle
// qualification that keeps a single late glitch from raising a time error.
module vita_tx_time_check (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic [63:0] vita_time,
  input  logic [63:0] send_time,
  input  logic [31:0] window,
  input  logic        src_rdy,
  input  logic        dst_rdy,
  output logic        now,
  output logic        late,
  output logic        too_early,
  output logic        time_err
);

  logic        late_qual;
  logic        late_del;
  logic [32:0] limit;

  assign now       = (vita_time == send_time);
  assign late      = (vita_time > send_time);
  // 33-bit sum so a huge window cannot wrap into a false too-early
  assign limit     = {1'b0, vita_time[63:32]} + {1'b0, window};
  assign too_early = (window != 32'd0) && ({1'b0, send_time[63:32]} > limit);

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      late_qual <= 1'b0;
      late_del  <= 1'b0;
    end else begin
      late_qual <= src_rdy & ~dst_rdy;
      late_del  <= late;
    end
  end

  assign time_err = late & late_qual & late_del;

endmodule

// File: rtl/vita_tx_control_mc.sv
// Multi-channel timed-transmit controller: releases packed FIFO samples to the
// DSP on strobe once send time is reached, and reports burst/underrun errors.
module vita_tx_control_mc
  import vita_tx_pkg::*;
#(
  parameter int BASE        = 0,
  parameter int WIDTH       = 32,
  parameter int NUM_CH      = 2,
  parameter int TO_W        = 24,
  parameter int DEF_TIMEOUT = 1000000
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clear,
  input  logic                      set_stb,
  input  logic [7:0]                set_addr,
  input  logic [31:0]               set_data,
  input  logic [63:0]               vita_time,
  input  logic [HDR_W+NUM_CH*WIDTH-1:0] sample_fifo_i,
  input  logic                      sample_fifo_src_rdy_i,
  output logic                      sample_fifo_dst_rdy_o,
  output logic [NUM_CH*WIDTH-1:0]   sample,
  output logic                      run,
  input  logic                      strobe,
  input  logic                      carrier_present,
  output logic                      error,
  output logic                      ack,
  output logic [31:0]               error_code,
  output logic                      packet_consumed,
  output logic [15:0]               underrun_count,
  output logic [31:0]               debug
);

  hdr_t                         hdr;
  logic                         src_rdy;
  logic                         dst_rdy;
  logic                         samp_en;
  logic [3:0]                   policy;
  logic [TO_W-1:0]              timeout;
  logic [TO_W-1:0]              countdown;
  logic [31:0]                  window;
  logic                         gate;
  logic                         now, late, too_early, time_err;
  state_t                       state, nxt;
  logic                         evt_err, evt_ack;
  logic [15:0]                  evt_code;
  logic [15:0]                  evt_seq;
  logic [15:0]                  last_seq;

  assign hdr     = sample_fifo_i[HDR_W-1:0];
  assign src_rdy = sample_fifo_src_rdy_i;
  assign gate    = policy[POL_LBT_EN] ? ~carrier_present : 1'b1;

  // settings survive a soft clear
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      policy  <= 4'd0;
      timeout <= TO_W'(DEF_TIMEOUT);
      window  <= 32'd0;
    end else if (set_stb) begin
      if (set_addr == 8'(BASE))     policy  <= set_data[3:0];
      if (set_addr == 8'(BASE + 1)) timeout <= set_data[TO_W-1:0];
      if (set_addr == 8'(BASE + 2)) window  <= set_data;
    end
  end

  vita_tx_time_check u_time (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .vita_time (vita_time),
    .send_time (hdr.send_time),
    .window    (window),
    .src_rdy   (src_rdy),
    .dst_rdy   (dst_rdy),
    .now       (now),
    .late      (late),
    .too_early (too_early),
    .time_err  (time_err)
  );

  always_ff @(posedge clk) begin
    if (!reset_n || clear) state <= ST_IDLE;
    else                   state <= nxt;
  end

  always_comb begin
    nxt      = state;
    evt_err  = 1'b0;
    evt_ack  = 1'b0;
    evt_code = 16'd0;
    case (state)
      ST_IDLE: begin
        if (src_rdy & gate) begin
          if (hdr.seqnum_err) begin
            nxt = ST_ERROR; evt_err = 1'b1; evt_code = CODE_SEQ_ERROR;
          end else if (too_early) begin
            nxt = ST_ERROR; evt_err = 1'b1; evt_code = CODE_TIME_ERROR;
          end else if (~hdr.send_at | now) begin
            nxt = ST_RUN;
          end else if (time_err) begin
            nxt = ST_ERROR; evt_err = 1'b1; evt_code = CODE_TIME_ERROR;
          end
        end
      end
      ST_RUN: begin
        if (strobe) begin
          if (~src_rdy) begin
            nxt = ST_ERROR; evt_err = 1'b1; evt_code = CODE_UNDERRUN_MIDPKT;
          end else if (hdr.eop & hdr.eob) begin
            nxt = ST_ERROR_DONE; evt_ack = 1'b1; evt_code = CODE_EOB_ACK;
          end else if (hdr.eop) begin
            nxt = ST_CONT_BURST;
          end
        end
      end
      ST_CONT_BURST: begin
        // a strobe here means the DSP outran the next packet, even if it just arrived
        if (strobe) begin
          evt_err  = 1'b1;
          evt_code = CODE_UNDERRUN;
          nxt      = policy[POL_NEXT_PACKET] ? ST_ERROR_DONE :
                     policy[POL_WAIT]        ? ST_ERROR_WAIT : ST_ERROR;
        end else if (src_rdy) begin
          if (hdr.seqnum_err) begin
            nxt = ST_ERROR; evt_err = 1'b1; evt_code = CODE_SEQ_ERROR_MIDBURST;
          end else if (gate) begin
            nxt = ST_RUN;
          end else begin
            nxt = ST_IDLE;
          end
        end
      end
      ST_ERROR: begin
        if (src_rdy & hdr.eop) begin
          if (policy[POL_NEXT_PACKET] | (policy[POL_NEXT_BURST] & hdr.eob)) nxt = ST_IDLE;
          else if (policy[POL_WAIT])                                        nxt = ST_ERROR_WAIT;
        end
      end
      ST_ERROR_DONE: nxt = ST_IDLE;
      ST_ERROR_WAIT: nxt = ST_ERROR_WAIT;
      default:       nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    dst_rdy = (state == ST_ERROR) | (strobe & (state == ST_RUN));
    samp_en = (state == ST_RUN);
  end

  assign sample_fifo_dst_rdy_o = dst_rdy;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign sample[k*WIDTH +: WIDTH] =
      samp_en ? sample_fifo_i[samp_lsb(k, WIDTH) +: WIDTH] : {WIDTH{1'b0}};
  end

  // an empty FIFO has no valid seqnum, so report the last one consumed
  assign evt_seq = src_rdy ? hdr.seqnum : last_seq;

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      error           <= 1'b0;
      ack             <= 1'b0;
      error_code      <= 32'd0;
      packet_consumed <= 1'b0;
      last_seq        <= 16'd0;
      run             <= 1'b0;
      countdown       <= '0;
      debug           <= 32'd0;
    end else begin
      error           <= evt_err;
      ack             <= evt_ack;
      if (evt_err | evt_ack) error_code <= {evt_seq, evt_code};
      packet_consumed <= src_rdy & dst_rdy & hdr.eop;
      if (src_rdy & dst_rdy) last_seq <= hdr.seqnum;
      if (state == ST_RUN) begin
        countdown <= timeout;
        run       <= ~(strobe & src_rdy & hdr.eob & hdr.eop);
      end else begin
        countdown <= (countdown == '0) ? '0 : countdown - TO_W'(1);
        if (countdown <= TO_W'(1)) run <= 1'b0;
        if (policy[POL_LBT_EN] & carrier_present &
            ((state == ST_IDLE) | (state == ST_CONT_BURST))) run <= 1'b0;
      end
      debug <= {state, src_rdy, dst_rdy, strobe, carrier_present, gate, run, error, ack,
                now, late, too_early, time_err, hdr.sob, policy, 12'd0};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      underrun_count <= 16'd0;
    end else if (!clear && evt_err && underrun_count != 16'hFFFF &&
                 (evt_code == CODE_UNDERRUN || evt_code == CODE_UNDERRUN_MIDPKT)) begin
      underrun_count <= underrun_count + 16'd1;
    end
  end

endmodule

// File: doc/vita_tx_control_mc.md
Name: vita_tx_control_mc

Overview:
Multi-channel, parametrised timed-transmit controller between the VITA TX deframer sample FIFO and the DSP TX core(s).
- Releases samples on `strobe` once a packet's send time is reached.
- Tracks burst state and reports errors, policy-driven.
- Adds over the single-channel controller: N packed channels, programmable idle timeout, switchable listen-before-talk (LBT) gating, a saturating underrun counter and a live too-early window check.

Parameters:
BASE, 0, settings-bus base address (uses BASE+0..BASE+2)
WIDTH, 32, bits per channel sample
NUM_CH, 2, channels packed in one FIFO word (1..4)
TO_W, 24, idle-timeout counter width
DEF_TIMEOUT, 1000000, idle-timeout reset value (cycles)

Ports:
clk  in  1  sole clock
reset_n  in  1  synchronous, active-low reset
clear  in  1  sync soft clear; same effect as reset except settings registers
set_stb  in  1  settings strobe
set_addr  in  8  settings address
set_data  in  32  settings data
vita_time  in  64  current VITA time
sample_fifo_i  in  85+NUM_CH*WIDTH  {samples, seqnum_err, send_at, sob, eob, eop, seqnum[15:0], send_time[63:0]}
sample_fifo_src_rdy_i  in  1  FIFO word valid
sample_fifo_dst_rdy_o  out  1  pop FIFO word
sample  out  NUM_CH*WIDTH  channel k at [k*WIDTH+:WIDTH]
run  out  1  DSP enable
strobe  in  1  DSP sample request
carrier_present  in  1  channel busy, from the RX energy detector
error  out  1  one-cycle error pulse
ack  out  1  one-cycle EOB ack pulse
error_code  out  32  {seqnum,flags}
packet_consumed  out  1  registered: eop word popped
underrun_count  out  16  saturating count of CODE_UNDERRUN/UNDERRUN_MIDPKT events
debug  out  32  state, handshakes, flags

Behaviour:
- Settings:
  - BASE+0 policy: [0] wait, [1] next_packet, [2] next_burst, [3] lbt_en. Reset value 0.
  - BASE+1 idle timeout, TO_W LSBs. Reset value DEF_TIMEOUT.
  - BASE+2 too-early window in seconds (upper 32 bits of time); 0 disables. Reset value 0.
- Reset/clear outputs: every output 0 except `sample` (0 whenever state≠RUN); state IDLE; countdown 0. `underrun_count` clears on reset only, not on clear.
- Time compare, against the head word's send_time:
  - now: vita_time==send_time
  - late: vita_time>send_time
  - too_early: window≠0 and send_time[63:32] > vita_time[63:32]+window
- late_qual: registered (src_rdy & ~dst_rdy). late_del: registered late. Time error requires late & late_qual & late_del, i.e. late persisting ≥2 cycles on an unconsumed head.
- gate: lbt_en ? ~carrier_present : 1.
- States: IDLE, RUN, CONT_BURST, ERROR, ERROR_DONE, ERROR_WAIT.
  - IDLE, on src_rdy & gate:
    - seqnum_err → ERROR, code SEQ(4)
    - else too_early → ERROR, code TIME(8)
    - else ~send_at|now → RUN
    - else time error → ERROR, code TIME(8)
  - RUN, on strobe:
    - ~src_rdy → ERROR, code UNDERRUN_MIDPKT(16)
    - else eop&eob → ERROR_DONE, code EOB_ACK(1), ack
    - else eop → CONT_BURST
  - CONT_BURST:
    - strobe → code UNDERRUN(2); next state: next_packet ? ERROR_DONE : wait ? ERROR_WAIT : ERROR
    - else src_rdy: seqnum_err → ERROR, code SEQ_MIDBURST(32); else gate → RUN; else IDLE
  - ERROR: flush. On src_rdy&eop: next_packet | (next_burst&eob) → IDLE; else wait → ERROR_WAIT.
  - ERROR_DONE: → IDLE after 1 cycle.
  - ERROR_WAIT: exit only via clear/reset.
- Pulse timing: `error`/`ack` assert the cycle after the transition decision and last exactly 1 cycle. `error_code` holds until the next error.
- Pop rule: dst_rdy = (state==ERROR) | (strobe & state==RUN). Combinational, no added latency; `sample` is the head word in RUN.
- run:
  - RUN: run=1 and countdown←timeout; on the eob&eop&strobe&src_rdy pop, run←0.
  - Outside RUN: countdown decrements to 0 then run←0. lbt_en & carrier_present in IDLE/CONT_BURST forces run←0 the next cycle.
  - Countdown saturates at 0 (no wrap).
- Simultaneous events:
  - strobe & src_rdy in CONT_BURST: strobe wins (underrun).
  - clear with a pulse pending: clear wins.
  - Settings write mid-burst: takes effect next cycle.
- underrun_count saturates at 16'hFFFF.

Decomposition:
- Package vita_tx_pkg: state encodings (3-bit), code flag constants (1,2,4,8,16,32), policy bit indices, FIFO field offsets as functions of NUM_CH/WIDTH.
- Sub-module: vita_tx_time_check. Registered late_qual/late_del qualification, now/late/too_early, window compare. Instantiated once.
- Settings via existing setting_reg.

Test Plan:
- NUM_CH=2, send_at=0, 3-word eob packet, strobe every cycle → RUN; 3 pops; ack pulse; error_code={seq,16'd1}; run low after last pop.
- send_time=1000, vita_time=990 → no pop; RUN at 1000; first sample on the first strobe ≥1000.
- send_time=500, vita_time=600, FIFO held → error at cycle 3 with code 8, then flush to eop; policy next_packet → IDLE.
- Non-eob packet, FIFO empty, strobe in CONT_BURST, policy wait → code 2, ERROR_WAIT; underrun_count=1; stays until clear.
- lbt_en=1, carrier_present=1 with a packet ready → no pop, run=0; carrier drops → RUN next cycle.
- timeout=10, burst ends mid-stream → run falls 10 cycles after leaving RUN; reset_n=0 mid-RUN → all outputs 0 next edge.
